// File: rtl/vtg_prog_if.sv
// Configuration port of the programmable video timing generator: pending-register
// writes, commit request, and the commit status flags returned by the generator.
interface vtg_prog_if;
  logic        cfg_wr;
  logic [2:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic        cfg_commit;
  logic        cfg_pending;
  logic        cfg_err;

  modport master (
    output cfg_wr, cfg_addr, cfg_wdata, cfg_commit,
    input  cfg_pending, cfg_err
  );

  modport slave (
    input  cfg_wr, cfg_addr, cfg_wdata, cfg_commit,
    output cfg_pending, cfg_err
  );
endinterface

// File: rtl/vtg_prog.sv
// Programmable raster timing generator: free-running (sx,sy) counters with registered
// sync/de/sof/eol, and a double-buffered timing set that only changes at frame boundaries.
module vtg_prog #(
  parameter int X_WIDTH  = 12,
  parameter int Y_WIDTH  = 11,
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SYNC   = 44,
  parameter int H_TOTAL  = 2200,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_TOTAL  = 1125,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  vtg_prog_if.slave          cfg,
  output logic [X_WIDTH-1:0] sx,
  output logic [Y_WIDTH-1:0] sy,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic               sof,
  output logic               eol,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  typedef struct packed {
    logic [X_WIDTH-1:0] h_active;
    logic [X_WIDTH-1:0] h_fp;
    logic [X_WIDTH-1:0] h_sync;
    logic [X_WIDTH-1:0] h_total;
    logic [Y_WIDTH-1:0] v_active;
    logic [Y_WIDTH-1:0] v_fp;
    logic [Y_WIDTH-1:0] v_sync;
    logic [Y_WIDTH-1:0] v_total;
  } timing_t;

  localparam timing_t RESET_TIMING = '{
    h_active: X_WIDTH'(H_ACTIVE), h_fp: X_WIDTH'(H_FP),
    h_sync:   X_WIDTH'(H_SYNC),   h_total: X_WIDTH'(H_TOTAL),
    v_active: Y_WIDTH'(V_ACTIVE), v_fp: Y_WIDTH'(V_FP),
    v_sync:   Y_WIDTH'(V_SYNC),   v_total: Y_WIDTH'(V_TOTAL)
  };

  // Sums of three fields are formed two bits wider so they can never wrap.
  localparam int XE = X_WIDTH + 2;
  localparam int YE = Y_WIDTH + 2;

  state_e             state_q, state_d;
  logic [X_WIDTH-1:0] sx_q, sx_d;
  logic [Y_WIDTH-1:0] sy_q, sy_d;
  timing_t            act_q, act_d;
  timing_t            pend_q, pend_d;
  logic               pending_q, pending_d;
  logic               err_q, err_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               de_q, de_d;
  logic               sof_q, sof_d;
  logic               eol_q, eol_d;
  logic               busy_q, busy_d;

  logic               last_x, last_y, last_pix, apply, pend_ok, run_d;
  logic [XE-1:0]      h_sum, hs_lo, hs_hi;
  logic [YE-1:0]      v_sum, vs_lo, vs_hi;

  // NOTE: every variable gets a default at the top of the block so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d   = state_q;
    sx_d      = sx_q;
    sy_d      = sy_q;
    act_d     = act_q;
    pend_d    = pend_q;
    pending_d = pending_q;
    err_d     = err_q;

    last_x   = (sx_q == act_q.h_total - X_WIDTH'(1));
    last_y   = (sy_q == act_q.v_total - Y_WIDTH'(1));
    last_pix = (state_q != IDLE) && last_x && last_y;

    h_sum   = {2'b00, pend_q.h_active} + {2'b00, pend_q.h_fp} + {2'b00, pend_q.h_sync};
    v_sum   = {2'b00, pend_q.v_active} + {2'b00, pend_q.v_fp} + {2'b00, pend_q.v_sync};
    pend_ok = (pend_q.h_active != '0) && (pend_q.h_sync != '0) &&
              (pend_q.h_total >= X_WIDTH'(2)) && (h_sum <= {2'b00, pend_q.h_total}) &&
              (pend_q.v_active != '0) && (pend_q.v_sync != '0) &&
              (pend_q.v_total >= Y_WIDTH'(2)) && (v_sum <= {2'b00, pend_q.v_total});

    if (cfg.cfg_wr) begin
      case (cfg.cfg_addr)
        3'd0:    pend_d.h_active = cfg.cfg_wdata[X_WIDTH-1:0];
        3'd1:    pend_d.h_fp     = cfg.cfg_wdata[X_WIDTH-1:0];
        3'd2:    pend_d.h_sync   = cfg.cfg_wdata[X_WIDTH-1:0];
        3'd3:    pend_d.h_total  = cfg.cfg_wdata[X_WIDTH-1:0];
        3'd4:    pend_d.v_active = cfg.cfg_wdata[Y_WIDTH-1:0];
        3'd5:    pend_d.v_fp     = cfg.cfg_wdata[Y_WIDTH-1:0];
        3'd6:    pend_d.v_sync   = cfg.cfg_wdata[Y_WIDTH-1:0];
        default: pend_d.v_total  = cfg.cfg_wdata[Y_WIDTH-1:0];
      endcase
    end

    // The applied set is the registered pending set, so a same-cycle write misses it.
    apply = pending_q && ((state_q == IDLE) || last_pix);
    if (apply) begin
      pending_d = 1'b0;
      if (pend_ok) begin
        act_d = pend_q;
        err_d = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end else if (cfg.cfg_commit) begin
      pending_d = 1'b1;
    end

    case (state_q)
      IDLE: if (en) state_d = RUN;
      default: begin
        if (last_pix && !en) begin
          state_d = IDLE;
          sx_d    = '0;
          sy_d    = '0;
        end else begin
          state_d = en ? RUN : DRAIN;
          if (last_x) begin
            sx_d = '0;
            sy_d = last_y ? '0 : sy_q + Y_WIDTH'(1);
          end else begin
            sx_d = sx_q + X_WIDTH'(1);
          end
        end
      end
    endcase

    // Outputs are decoded from the next position under the timing that will be active.
    run_d  = (state_d != IDLE);
    hs_lo  = {2'b00, act_d.h_active} + {2'b00, act_d.h_fp};
    hs_hi  = hs_lo + {2'b00, act_d.h_sync};
    vs_lo  = {2'b00, act_d.v_active} + {2'b00, act_d.v_fp};
    vs_hi  = vs_lo + {2'b00, act_d.v_sync};

    hsync_d = (run_d && ({2'b00, sx_d} >= hs_lo) && ({2'b00, sx_d} < hs_hi)) ? HS_POL : ~HS_POL;
    vsync_d = (run_d && ({2'b00, sy_d} >= vs_lo) && ({2'b00, sy_d} < vs_hi)) ? VS_POL : ~VS_POL;
    de_d    = run_d && (sx_d < act_d.h_active) && (sy_d < act_d.v_active);
    sof_d   = run_d && (sx_d == '0) && (sy_d == '0);
    eol_d   = run_d && (sx_d == act_d.h_total - X_WIDTH'(1));
    busy_d  = run_d;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  // NOTE: the timing sets are a handful of flops, not a memory array, so they are
  // reset like any other state and come up holding the parameter timing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sx_q      <= '0;
      sy_q      <= '0;
      act_q     <= RESET_TIMING;
      pend_q    <= RESET_TIMING;
      pending_q <= 1'b0;
      err_q     <= 1'b0;
      hsync_q   <= ~HS_POL;
      vsync_q   <= ~VS_POL;
      de_q      <= 1'b0;
      sof_q     <= 1'b0;
      eol_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sx_q      <= sx_d;
      sy_q      <= sy_d;
      act_q     <= act_d;
      pend_q    <= pend_d;
      pending_q <= pending_d;
      err_q     <= err_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      de_q      <= de_d;
      sof_q     <= sof_d;
      eol_q     <= eol_d;
      busy_q    <= busy_d;
    end
  end

  assign sx              = sx_q;
  assign sy              = sy_q;
  assign hsync           = hsync_q;
  assign vsync           = vsync_q;
  assign de              = de_q;
  assign sof             = sof_q;
  assign eol             = eol_q;
  assign busy            = busy_q;
  assign cfg.cfg_pending = pending_q;
  assign cfg.cfg_err     = err_q;

endmodule

// File: tb/tb_vtg_prog.sv
// Bench for vtg_prog: two instances (sync active-high and active-low) driven identically,
// compared every cycle against a frame-index model plus hand-computed frame figures.
module tb_vtg_prog;
  localparam int XW = 12;
  localparam int YW = 11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;

  vtg_prog_if cfg_a ();
  vtg_prog_if cfg_b ();

  logic [XW-1:0] sx, sx_b;
  logic [YW-1:0] sy, sy_b;
  logic hsync, vsync, de, sof, eol, busy;
  logic hsync_b, vsync_b, de_b, sof_b, eol_b, busy_b;

  assign cfg_b.cfg_wr     = cfg_a.cfg_wr;
  assign cfg_b.cfg_addr   = cfg_a.cfg_addr;
  assign cfg_b.cfg_wdata  = cfg_a.cfg_wdata;
  assign cfg_b.cfg_commit = cfg_a.cfg_commit;

  vtg_prog #(
    .X_WIDTH(XW), .Y_WIDTH(YW),
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_TOTAL(16),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_TOTAL(8),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cfg(cfg_a),
    .sx(sx), .sy(sy), .hsync(hsync), .vsync(vsync), .de(de),
    .sof(sof), .eol(eol), .busy(busy)
  );

  vtg_prog #(
    .X_WIDTH(XW), .Y_WIDTH(YW),
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_TOTAL(16),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_TOTAL(8),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .cfg(cfg_b),
    .sx(sx_b), .sy(sy_b), .hsync(hsync_b), .vsync(vsync_b), .de(de_b),
    .sof(sof_b), .eol(eol_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Model: the frame is a linear pixel index; position and flags follow by division.
  int m_act[8];
  int m_pend[8];
  bit m_run, m_pending, m_err;
  int m_p;

  function automatic int field_mask(input logic [2:0] a);
    return (a < 3'd4) ? 32'h0FFF : 32'h07FF;
  endfunction

  function automatic bit set_ok(input int s[8]);
    return s[0] >= 1 && s[2] >= 1 && s[3] >= 2 && s[0] + s[1] + s[2] <= s[3] &&
           s[4] >= 1 && s[6] >= 1 && s[7] >= 2 && s[4] + s[5] + s[6] <= s[7];
  endfunction

  task automatic model_reset();
    m_act     = '{8, 2, 2, 16, 4, 1, 1, 8};
    m_pend    = '{8, 2, 2, 16, 4, 1, 1, 8};
    m_run     = 1'b0;
    m_pending = 1'b0;
    m_err     = 1'b0;
    m_p       = 0;
  endtask

  task automatic model_step();
    int  old_pend[8];
    bit  last, apply;
    last     = m_run && (m_p == m_act[3] * m_act[7] - 1);
    apply    = m_pending && (!m_run || last);
    old_pend = m_pend;
    if (cfg_a.cfg_wr)
      m_pend[cfg_a.cfg_addr] = int'(cfg_a.cfg_wdata) & field_mask(cfg_a.cfg_addr);
    if (apply) begin
      m_pending = 1'b0;
      if (set_ok(old_pend)) begin
        m_act = old_pend;
        m_err = 1'b0;
      end else begin
        m_err = 1'b1;
      end
    end else if (cfg_a.cfg_commit) begin
      m_pending = 1'b1;
    end
    if (!m_run) begin
      if (en) begin
        m_run = 1'b1;
        m_p   = 0;
      end
    end else if (last) begin
      m_p = 0;
      if (!en) m_run = 1'b0;
    end else begin
      m_p++;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  task automatic compare_all();
    int x, y;
    bit hs, vs, d, s, e;
    x  = m_run ? m_p % m_act[3] : 0;
    y  = m_run ? m_p / m_act[3] : 0;
    hs = m_run && x >= m_act[0] + m_act[1] && x < m_act[0] + m_act[1] + m_act[2];
    vs = m_run && y >= m_act[4] + m_act[5] && y < m_act[4] + m_act[5] + m_act[6];
    d  = m_run && x < m_act[0] && y < m_act[4];
    s  = m_run && m_p == 0;
    e  = m_run && x == m_act[3] - 1;
    check("sx", 32'(sx), 32'(x));
    check("sy", 32'(sy), 32'(y));
    check("hsync", 32'(hsync), 32'(hs));
    check("vsync", 32'(vsync), 32'(vs));
    check("de", 32'(de), 32'(d));
    check("sof", 32'(sof), 32'(s));
    check("eol", 32'(eol), 32'(e));
    check("busy", 32'(busy), 32'(m_run));
    check("cfg_pending", 32'(cfg_a.cfg_pending), 32'(m_pending));
    check("cfg_err", 32'(cfg_a.cfg_err), 32'(m_err));
    check("sx_b", 32'(sx_b), 32'(x));
    check("sy_b", 32'(sy_b), 32'(y));
    check("hsync_b", 32'(hsync_b), 32'(!hs));
    check("vsync_b", 32'(vsync_b), 32'(!vs));
    check("de_b", 32'(de_b), 32'(d));
    check("sof_b", 32'(sof_b), 32'(s));
    check("eol_b", 32'(eol_b), 32'(e));
    check("busy_b", 32'(busy_b), 32'(m_run));
    check("cfg_pending_b", 32'(cfg_b.cfg_pending), 32'(m_pending));
    check("cfg_err_b", 32'(cfg_b.cfg_err), 32'(m_err));
  endtask

  initial forever begin
    @(negedge clk);
    compare_all();
  end

  task automatic cfg_write(input logic [2:0] a, input logic [15:0] d);
    cfg_a.cfg_wr    = 1'b1;
    cfg_a.cfg_addr  = a;
    cfg_a.cfg_wdata = d;
    @(negedge clk);
    cfg_a.cfg_wr    = 1'b0;
  endtask

  task automatic cfg_commit_pulse();
    cfg_a.cfg_commit = 1'b1;
    @(negedge clk);
    cfg_a.cfg_commit = 1'b0;
  endtask

  task automatic wait_pos(input int x, input int y);
    int n = 0;
    while (!(busy && int'(sx) == x && int'(sy) == y) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("reach_pos", 32'(busy && int'(sx) == x && int'(sy) == y), 32'd1);
  endtask

  task automatic wait_sof();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sof && n < 4000);
    check("sof_seen", 32'(sof), 32'd1);
  endtask

  // Called on a sof cycle; returns on the next sof cycle.
  task automatic measure_frame(output int de_cnt, output int len,
                               output logic [31:0] hs_mask, output logic [31:0] vs_mask,
                               output logic [31:0] hsb_mask);
    de_cnt = 0; len = 0; hs_mask = '0; vs_mask = '0; hsb_mask = '0;
    do begin
      if (de) de_cnt++;
      if (hsync && sx < 32) hs_mask[sx[4:0]] = 1'b1;
      if (vsync && sy < 32) vs_mask[sy[4:0]] = 1'b1;
      if (!hsync_b && sx < 32) hsb_mask[sx[4:0]] = 1'b1;
      len++;
      @(negedge clk);
    end while (!sof && len < 4000);
  endtask

  initial begin
    int de_cnt, len, dcnt, n, lx, ly;
    logic [31:0] hs_mask, vs_mask, hsb_mask;
    logic [2:0] a;
    int val;

    cfg_a.cfg_wr = 1'b0; cfg_a.cfg_addr = '0; cfg_a.cfg_wdata = '0; cfg_a.cfg_commit = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_hsync", 32'(hsync), 32'd0);
    check("idle_hsync_neg", 32'(hsync_b), 32'd1);
    check("idle_vsync_neg", 32'(vsync_b), 32'd1);

    // Parameter timing: syncs, de count and frame length.
    en = 1'b1;
    wait_sof();
    check("first_pos", 32'({sx, sy}), 32'd0);
    measure_frame(de_cnt, len, hs_mask, vs_mask, hsb_mask);
    check("frame_de", 32'(de_cnt), 32'd32);
    check("frame_len", 32'(len), 32'd128);
    check("hs_mask", hs_mask, 32'h0000_0C00);
    check("vs_mask", vs_mask, 32'h0000_0020);
    check("hs_neg_mask", hsb_mask, 32'h0000_0C00);

    // Mid-frame narrowing: current frame unaffected, next frame 4-pixel lines.
    wait_pos(0, 2);
    cfg_write(3'd0, 16'd4);
    cfg_commit_pulse();
    wait_pos(0, 3);
    check("pend_mid", 32'(cfg_a.cfg_pending), 32'd1);
    dcnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (de) dcnt++;
      @(negedge clk);
    end
    check("old_line_de", 32'(dcnt), 32'd8);
    wait_pos(15, 7);
    check("pend_last_pix", 32'(cfg_a.cfg_pending), 32'd1);
    wait_sof();
    check("pend_cleared", 32'(cfg_a.cfg_pending), 32'd0);
    measure_frame(de_cnt, len, hs_mask, vs_mask, hsb_mask);
    check("narrow_de", 32'(de_cnt), 32'd16);
    check("narrow_hs", hs_mask, 32'h0000_00C0);

    // Invalid set keeps timing and raises the sticky error; a valid one clears it.
    cfg_write(3'd0, 16'd8);
    cfg_write(3'd1, 16'd10);
    cfg_commit_pulse();
    wait_sof();
    check("bad_err", 32'(cfg_a.cfg_err), 32'd1);
    check("bad_pend", 32'(cfg_a.cfg_pending), 32'd0);
    measure_frame(de_cnt, len, hs_mask, vs_mask, hsb_mask);
    check("bad_de", 32'(de_cnt), 32'd16);
    check("bad_hs", hs_mask, 32'h0000_00C0);
    cfg_write(3'd1, 16'd2);
    cfg_commit_pulse();
    wait_sof();
    check("good_err", 32'(cfg_a.cfg_err), 32'd0);
    measure_frame(de_cnt, len, hs_mask, vs_mask, hsb_mask);
    check("good_de", 32'(de_cnt), 32'd32);
    check("good_hs", hs_mask, 32'h0000_0C00);

    // Drop en mid-frame: the frame runs out to (15,7), then idle.
    wait_pos(0, 3);
    en = 1'b0;
    lx = 0; ly = 0; n = 0;
    while (busy && n < 400) begin
      lx = int'(sx);
      ly = int'(sy);
      @(negedge clk);
      n++;
    end
    check("drain_last_x", 32'(lx), 32'd15);
    check("drain_last_y", 32'(ly), 32'd7);
    check("drain_idle", 32'(busy), 32'd0);
    check("drain_idle_sx", 32'(sx), 32'd0);

    // Re-raise en while draining: counting continues without a gap.
    en = 1'b1;
    wait_pos(0, 2);
    en = 1'b0;
    repeat (20) @(negedge clk);
    check("rerun_x", 32'(sx), 32'd4);
    check("rerun_y", 32'(sy), 32'd3);
    check("rerun_busy", 32'(busy), 32'd1);
    en = 1'b1;

    // Reset mid-frame reloads parameter timing.
    cfg_write(3'd0, 16'd6);
    cfg_commit_pulse();
    wait_sof();
    measure_frame(de_cnt, len, hs_mask, vs_mask, hsb_mask);
    check("six_de", 32'(de_cnt), 32'd24);
    wait_pos(4, 2);
    @(posedge clk);
    #2;
    check("pre_rst_x", 32'(sx), 32'd5);
    rst_n = 1'b0;
    #1;
    check("rst_sx", 32'(sx), 32'd0);
    check("rst_sy", 32'(sy), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_de", 32'(de), 32'd0);
    check("rst_hsync", 32'(hsync), 32'd0);
    check("rst_hsync_neg", 32'(hsync_b), 32'd1);
    check("rst_pending", 32'(cfg_a.cfg_pending), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_sof();
    measure_frame(de_cnt, len, hs_mask, vs_mask, hsb_mask);
    check("post_rst_de", 32'(de_cnt), 32'd32);
    check("post_rst_len", 32'(len), 32'd128);

    // Randomized traffic: en toggling, writes with junk high bits, commits.
    for (int i = 0; i < 6000; i++) begin
      en = ($urandom_range(0, 99) < 90);
      cfg_a.cfg_wr = ($urandom_range(0, 99) < 4);
      cfg_a.cfg_commit = ($urandom_range(0, 99) < 2);
      a = 3'($urandom_range(0, 7));
      case (a)
        3'd3:    val = $urandom_range(2, 28);
        3'd7:    val = $urandom_range(2, 14);
        3'd4, 3'd5, 3'd6: val = $urandom_range(0, 6);
        default: val = $urandom_range(0, 12);
      endcase
      cfg_a.cfg_addr  = a;
      cfg_a.cfg_wdata = 16'(val) | (16'($urandom) & ((a < 3'd4) ? 16'hF000 : 16'hF800));
      @(negedge clk);
    end
    cfg_a.cfg_wr = 1'b0;
    cfg_a.cfg_commit = 1'b0;
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vtg_prog.md
VTG_PROG -- requirements
Module: vtg_prog

Interface
REQ-001 SHALL have parameter X_WIDTH, default 12, meaning horizontal counter and H-field width.
REQ-002 SHALL have parameter Y_WIDTH, default 11, meaning vertical counter and V-field width.
REQ-003 SHALL have parameters H_ACTIVE/H_FP/H_SYNC/H_TOTAL, defaults 1920/88/44/2200, meaning reset horizontal timing.
REQ-004 SHALL have parameters V_ACTIVE/V_FP/V_SYNC/V_TOTAL, defaults 1080/4/5/1125, meaning reset vertical timing.
REQ-005 SHALL have parameters HS_POL and VS_POL, default 1, meaning sync active level (1 = active-high).
REQ-006 SHALL have port clk, input, 1, pixel clock; the block uses this single clock.
REQ-007 SHALL have port rst_n, input, 1, reset; asynchronous assertion, active-low.
REQ-008 SHALL have port en, input, 1, run request.
REQ-009 SHALL have port cfg_wr, input, 1, one-cycle write strobe to a pending timing register.
REQ-010 SHALL have port cfg_addr, input, 3, register select: 0 H_ACTIVE, 1 H_FP, 2 H_SYNC, 3 H_TOTAL, 4 V_ACTIVE, 5 V_FP, 6 V_SYNC, 7 V_TOTAL.
REQ-011 SHALL have port cfg_wdata, input, 16, write data; low X_WIDTH (H) or Y_WIDTH (V) bits stored, rest ignored.
REQ-012 SHALL have port cfg_commit, input, 1, one-cycle request to apply pending set.
REQ-013 SHALL have outputs: sx (X_WIDTH), sy (Y_WIDTH), hsync, vsync, de, sof (start of frame), eol (last pixel of line), busy, cfg_pending, cfg_err, all 1 bit unless stated.

Function
REQ-014 SHALL implement states IDLE, RUN, DRAIN.
REQ-015 IDLE: sx=sy=0, de=0, sof=0, eol=0, syncs at inactive level, busy=0; en=1 -> RUN next cycle.
REQ-016 RUN: sx increments each cycle; at sx=H_TOTAL-1 sx->0 and sy increments; at sy=V_TOTAL-1 with sx=H_TOTAL-1, sy->0.
REQ-017 RUN with en=0 -> DRAIN; DRAIN continues counting, en=1 returns to RUN; at last pixel of frame DRAIN -> IDLE (sx,sy cleared).
REQ-018 busy SHALL be 1 in RUN and DRAIN.
REQ-019 hsync, vsync, de, sof, eol SHALL be registered and describe the (sx,sy) presented in the same cycle.
REQ-020 hsync active when H_ACTIVE+H_FP <= sx < H_ACTIVE+H_FP+H_SYNC; vsync likewise on sy with V fields; active level per HS_POL/VS_POL.
REQ-021 de = 1 when sx < H_ACTIVE and sy < V_ACTIVE, only in RUN/DRAIN.
REQ-022 sof = 1 when sx=0 and sy=0 in RUN/DRAIN; eol = 1 when sx=H_TOTAL-1 in RUN/DRAIN.
REQ-023 cfg_wr SHALL update only pending registers; active timing unchanged until commit applied.
REQ-024 cfg_commit sets cfg_pending=1; apply point = last pixel of frame in RUN/DRAIN, or next cycle in IDLE.
REQ-025 At apply point pending set SHALL be validated: ACTIVE>=1, SYNC>=1, TOTAL>=2, ACTIVE+FP+SYNC <= TOTAL (per axis, computed without overflow).
REQ-026 Valid: active set replaced, first pixel of next frame uses new timing, cfg_err cleared; invalid: active set kept, cfg_err set sticky; cfg_pending cleared either way.
REQ-027 cfg_wr and apply in same cycle: the write goes to pending only, not included in the applied set.
REQ-028 cfg_commit while cfg_pending=1 SHALL be absorbed (single apply).
REQ-029 Any apply SHALL change the frame only at a frame boundary; no mid-frame timing change.

Reset
REQ-030 rst_n=0 SHALL immediately force state IDLE, sx=sy=0, de=sof=eol=busy=cfg_pending=cfg_err=0, syncs inactive.
REQ-031 Reset SHALL load active and pending sets from the timing parameters; reset mid-frame abandons the frame.

Verification
REQ-032 Params H 8/2/2/16, V 4/1/1/8, en=1 -> hsync active sx=10..11, vsync sy=5, de 32 pixels/frame, sof every 128 cycles.
REQ-033 HS_POL=0 -> hsync low at sx=10..11, high elsewhere and in IDLE/reset.
REQ-034 Mid-frame write H_ACTIVE=4, commit -> current frame keeps 8-pixel de, next frame de 4 pixels/line, cfg_pending falls at frame end.
REQ-035 Commit with H_FP=10 (8+10+2>16) -> timing unchanged, cfg_err=1; later valid commit -> cfg_err=0.
REQ-036 en dropped mid-frame -> frame completes to (15,7), then IDLE, busy=0; en re-raised in DRAIN -> no gap.
REQ-037 rst_n pulsed low at sx=5,sy=2 -> outputs cleared same cycle, restart at (0,0) with parameter timing.
